aes_mixcolumns_seq: RTL and testbench

Column-serial forward AES MixColumns engine with valid/ready handshakes on input and output. It accepts a 128-bit AES state and transforms one 32-bit column per clock through a single shared GF(2^8) column datapath. It returns the result on a held output. It sits in the encryption round path after ShiftRows and before AddRoundKey. A per-block bypass input skips the transform for the final round.

---
 rtl/aes_mixcolumns_seq_if.sv | 21 ++
 rtl/aes_mixcolumns_seq.sv | 89 ++++++++
 tb/tb_aes_mixcolumns_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_mixcolumns_seq_if.sv
// Handshake bundle for the column-serial MixColumns engine.
// The slave modport is the engine's view; the master modport is the upstream/downstream view.
interface aes_mixcolumns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_mixcolumns_seq.sv
// Column-serial forward AES MixColumns: one shared column datapath rewrites
// the 128-bit state one column per clock, then holds the result for the consumer.
module aes_mixcolumns_col (
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col_i;

  assign col_o = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                  xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes_mixcolumns_seq (
  input  logic                   clk,
  input  logic                   rst_n,
  aes_mixcolumns_seq_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0][31:0] data_q, data_d;   // index 3 holds column 0 (MSBs)
  logic [1:0]       cnt_q, cnt_d;
  logic             byp_q, byp_d;
  logic [31:0]      col_in, col_out;

  assign col_in = data_q[~cnt_q];

  aes_mixcolumns_col u_col (
    .col_i (col_in),
    .col_o (col_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    byp_d   = byp_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          cnt_d   = 2'd0;
          byp_d   = bus.in_bypass;
          state_d = CALC;
        end
      end
      CALC: begin
        // A bypass block spends one idle CALC edge so its output timing is
        // one edge after acceptance with no column written.
        if (byp_q) begin
          state_d = DONE;
        end else begin
          data_d[~cnt_q] = col_out;
          cnt_d          = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= 2'd0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      byp_q   <= byp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Self-checking bench for aes_mixcolumns_seq: directed vector table, corner
// sequences and a random stream against a GF(2^8) matrix reference model.
module tb_aes_mixcolumns_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_mixcolumns_seq_if bus();

  aes_mixcolumns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [127:0] din;
    logic         byp;
    int           hold;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // Circulant matrix multiply per column; inv selects the inverse matrix.
  function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   r;
    logic [127:0] o = '0;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - row) & 3], a[j]);
        o[127 - 32*c - 8*row -: 8] = r;
      end
    end
    return o;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
  endtask

  task automatic run_block(input vec_t v);
    int k;
    logic [127:0] held;
    wait_ready();
    bus.in_valid  = 1'b1;
    bus.in_data   = v.din;
    bus.in_bypass = v.byp;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    if (v.byp) begin
      @(posedge clk); #1;
      check({v.name, " valid_after_1"}, bus.out_valid, 1'b1);
    end else begin
      k = 0;
      while (!bus.out_valid && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      check({v.name, " latency"}, k, 4);
    end
    check({v.name, " in_ready_low"}, bus.in_ready, 1'b0);
    check({v.name, " data"}, bus.out_data, v.exp);
    held = bus.out_data;
    for (int h = 0; h < v.hold; h++) begin
      bus.in_valid = h[0];
      bus.in_data  = {4{32'hdeadbeef}};
      @(posedge clk); #1;
      check({v.name, " hold_data"}, bus.out_data, held);
      check({v.name, " hold_ready"}, bus.in_ready, 1'b0);
      check({v.name, " hold_valid"}, bus.out_valid, 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({v.name, " released_valid"}, bus.out_valid, 1'b0);
    check({v.name, " released_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    logic [127:0] q_in[$];
    logic         q_byp[$];
    logic [127:0] cur, exp_o, gin;
    logic         curb, gb, pending, bad;
    int           sent, got, cyc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0] = '{"single_col", 128'hdb135345_01010101_f20a225c_c6c6c6c6, 1'b0, 0,
               128'h8e4da1bc_01010101_9fdc589d_c6c6c6c6};
    tbl[1] = '{"fips_r1", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 10,
               128'h046681e5e0cb199a48f8d37a2806264c};
    tbl[2] = '{"bypass", 128'h00112233445566778899aabbccddeeff, 1'b1, 0,
               128'h00112233445566778899aabbccddeeff};
    tbl[3] = '{"d4_cols", {4{32'hd4d4d4d5}}, 1'b0, 0, {4{32'hd5d5d7d6}}};

    #1;
    check("reset in_ready", bus.in_ready, 1'b1);
    check("reset out_valid", bus.out_valid, 1'b0);
    check("reset out_data", bus.out_data, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_block(tbl[i]);

    // Reset two edges into CALC must clear everything without a clock edge.
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = tbl[1].din;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", bus.out_valid, 1'b0);
    check("midreset out_data", bus.out_data, 128'h0);
    check("midreset in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) bad = 1'b1;
    end
    check("post_reset no_valid", bad, 1'b0);
    run_block(tbl[3]);

    // Random stream with random in_valid/out_ready.
    pending = 1'b0; sent = 0; got = 0; cyc = 0;
    cur = '0; curb = 1'b0;
    while (got < 1000 && cyc < 60000) begin
      @(posedge clk); #1;
      if (!pending && sent < 1000) begin
        cur     = {$urandom, $urandom, $urandom, $urandom};
        curb    = ($urandom_range(3) == 0);
        pending = 1'b1;
      end
      bus.in_valid  = pending && ($urandom_range(3) != 0);
      bus.in_data   = cur;
      bus.in_bypass = curb;
      bus.out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        q_in.push_back(cur);
        q_byp.push_back(curb);
        pending = 1'b0;
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q_in.size() == 0) begin
          check("rand_extra_output", q_in.size(), 1);
        end else begin
          gin   = q_in.pop_front();
          gb    = q_byp.pop_front();
          exp_o = gb ? gin : mix(gin, 1'b0);
          check("rand_out", bus.out_data, exp_o);
          if (!gb) check("rand_inverse", mix(bus.out_data, 1'b1), gin);
        end
        got++;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_count", got, 1000);
    check("rand_queue_empty", q_in.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
